// File: rtl/trigger_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// trigger_sequencer_pkg
// Shared types and default widths for the multi-channel trigger sequencer.
//   chan_state_e     : per-channel sequencing state
//   DEF_*            : default parameter values used by the top level
//   MIN_/MAX_CHANNELS: supported channel count range
// -----------------------------------------------------------------------------
package trigger_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_HIGH  = 2'd2,
    ST_GAP   = 2'd3
  } chan_state_e;

  localparam int DEF_NUM_CHANNELS = 4;
  localparam int DEF_COUNT_WIDTH  = 16;
  localparam int DEF_REPEAT_WIDTH = 8;

  localparam int MIN_CHANNELS = 1;
  localparam int MAX_CHANNELS = 16;

endpackage : trigger_sequencer_pkg

// File: rtl/trigger_sequencer_channel.sv
// -----------------------------------------------------------------------------
// trigger_channel
// One output channel of the trigger sequencer: latches its configuration on an
// accepted edge, then walks DELAY -> (HIGH -> GAP)* -> HIGH -> IDLE using a
// single down-counter with terminal-count compare plus a repeat down-counter.
//
// Ports
//   clk_i      : clock
//   rst_i      : synchronous active-high reset
//   edge_i     : shared master-trigger rising-edge strobe
//   enable_i   : channel enable; dropping it while running aborts the sequence
//   delay_i    : cycles from edge to first pulse
//   length_i   : high cycles per pulse (0 = channel ignores edges)
//   period_i   : pulse start to pulse start; clamped to at least length+1
//   repeat_i   : pulses per trigger (0 treated as 1)
//   trigger_o  : registered pulse output
//   busy_o     : registered "sequence in progress"
//   missed_o   : one-cycle strobe when an edge arrives while busy
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for an edge; config inputs are live
// DELAY   | counting out the initial delay before the first pulse
// HIGH    | output high, counting out the pulse length
// GAP     | output low between pulses, counting out period - length
// -----------------------------------------------------------------------------
module trigger_channel
  import trigger_sequencer_pkg::*;
#(
  parameter int COUNT_WIDTH  = DEF_COUNT_WIDTH,
  parameter int REPEAT_WIDTH = DEF_REPEAT_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    edge_i,
  input  logic                    enable_i,
  input  logic [COUNT_WIDTH-1:0]  delay_i,
  input  logic [COUNT_WIDTH-1:0]  length_i,
  input  logic [COUNT_WIDTH-1:0]  period_i,
  input  logic [REPEAT_WIDTH-1:0] repeat_i,
  output logic                    trigger_o,
  output logic                    busy_o,
  output logic                    missed_o
);

  localparam logic [COUNT_WIDTH-1:0]  CNT_ONE  = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH:0]    PEFF_ONE = (COUNT_WIDTH + 1)'(1);
  localparam logic [REPEAT_WIDTH-1:0] REP_ONE  = REPEAT_WIDTH'(1);

  chan_state_e             state_q, state_d;
  logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0]  len_m1_q, len_m1_d;
  logic [COUNT_WIDTH-1:0]  gap_m1_q, gap_m1_d;
  logic [REPEAT_WIDTH-1:0] rep_q, rep_d;
  logic                    trig_q, trig_d;
  logic                    busy_q, busy_d;
  logic                    missed_q, missed_d;

  logic                    accept;
  logic [COUNT_WIDTH:0]    peff;
  logic [COUNT_WIDTH-1:0]  gap_m1_cfg;

  // Effective period is one bit wider so length+1 cannot wrap at full scale;
  // the resulting gap (peff - length) always fits back into COUNT_WIDTH.
  assign peff       = (period_i > length_i) ? {1'b0, period_i}
                                            : ({1'b0, length_i} + PEFF_ONE);
  assign gap_m1_cfg = COUNT_WIDTH'(peff - {1'b0, length_i} - PEFF_ONE);

  assign accept = edge_i && enable_i && (length_i != '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_m1_d = len_m1_q;
    gap_m1_d = gap_m1_q;
    rep_d    = rep_q;
    missed_d = edge_i && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          len_m1_d = length_i - CNT_ONE;
          gap_m1_d = gap_m1_cfg;
          // rep counts pulses still to come after the current one
          rep_d    = (repeat_i == '0) ? '0 : (repeat_i - REP_ONE);
          if (delay_i == '0) begin
            state_d = ST_HIGH;
            cnt_d   = length_i - CNT_ONE;
          end else begin
            state_d = ST_DELAY;
            cnt_d   = delay_i - CNT_ONE;
          end
        end
      end
      ST_DELAY, ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_HIGH;
          cnt_d   = len_m1_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (cnt_q == '0) begin
          if (rep_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            rep_d   = rep_q - REP_ONE;
            state_d = ST_GAP;
            cnt_d   = gap_m1_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q != ST_IDLE) && !enable_i) begin
      state_d = ST_IDLE;
    end

    // Outputs are registered decodes of the next state so they line up with it.
    trig_d = (state_d == ST_HIGH);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      len_m1_q <= '0;
      gap_m1_q <= '0;
      rep_q    <= '0;
      trig_q   <= 1'b0;
      busy_q   <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_m1_q <= len_m1_d;
      gap_m1_q <= gap_m1_d;
      rep_q    <= rep_d;
      trig_q   <= trig_d;
      busy_q   <= busy_d;
      missed_q <= missed_d;
    end
  end

  assign trigger_o = trig_q;
  assign busy_o    = busy_q;
  assign missed_o  = missed_q;

endmodule : trigger_channel

// File: rtl/trigger_sequencer.sv
// -----------------------------------------------------------------------------
// trigger_sequencer
// Multi-channel trigger sequencer. Detects the rising edge of the radar master
// trigger once and fans it out to NUM_CHANNELS independently programmed
// trigger_channel instances.
//
// Ports
//   ipClk     : clock
//   ipReset   : synchronous active-high reset
//   ipTrigger : master trigger (rising edge used)
//   ipEnable  : per-channel enable
//   ipDelay   : per-channel delay,  channel c at [c*COUNT_WIDTH +: COUNT_WIDTH]
//   ipLength  : per-channel pulse length
//   ipPeriod  : per-channel pulse period
//   ipRepeat  : per-channel pulse count, channel c at [c*REPEAT_WIDTH +: ...]
//   opTrigger : per-channel registered trigger outputs
//   opBusy    : per-channel sequence in progress
//   opMissed  : per-channel one-cycle dropped-edge strobe
// -----------------------------------------------------------------------------
module trigger_sequencer
  import trigger_sequencer_pkg::*;
#(
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int COUNT_WIDTH  = DEF_COUNT_WIDTH,
  parameter int REPEAT_WIDTH = DEF_REPEAT_WIDTH
) (
  input  logic                               ipClk,
  input  logic                               ipReset,
  input  logic                               ipTrigger,
  input  logic [NUM_CHANNELS-1:0]            ipEnable,
  input  logic [NUM_CHANNELS*COUNT_WIDTH-1:0]  ipDelay,
  input  logic [NUM_CHANNELS*COUNT_WIDTH-1:0]  ipLength,
  input  logic [NUM_CHANNELS*COUNT_WIDTH-1:0]  ipPeriod,
  input  logic [NUM_CHANNELS*REPEAT_WIDTH-1:0] ipRepeat,
  output logic [NUM_CHANNELS-1:0]            opTrigger,
  output logic [NUM_CHANNELS-1:0]            opBusy,
  output logic [NUM_CHANNELS-1:0]            opMissed
);

  logic trig_prev_q;
  logic armed_q;
  logic trig_edge;

  // armed_q stays low for the first cycle out of reset so a trigger that is
  // already high at release is not mistaken for a fresh edge.
  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      trig_prev_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      trig_prev_q <= ipTrigger;
      armed_q     <= 1'b1;
    end
  end

  assign trig_edge = ipTrigger && !trig_prev_q && armed_q;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    trigger_channel #(
      .COUNT_WIDTH  (COUNT_WIDTH),
      .REPEAT_WIDTH (REPEAT_WIDTH)
    ) u_chan (
      .clk_i     (ipClk),
      .rst_i     (ipReset),
      .edge_i    (trig_edge),
      .enable_i  (ipEnable[c]),
      .delay_i   (ipDelay [c*COUNT_WIDTH  +: COUNT_WIDTH]),
      .length_i  (ipLength[c*COUNT_WIDTH  +: COUNT_WIDTH]),
      .period_i  (ipPeriod[c*COUNT_WIDTH  +: COUNT_WIDTH]),
      .repeat_i  (ipRepeat[c*REPEAT_WIDTH +: REPEAT_WIDTH]),
      .trigger_o (opTrigger[c]),
      .busy_o    (opBusy[c]),
      .missed_o  (opMissed[c])
    );
  end

endmodule : trigger_sequencer

// File: tb/tb_trigger_sequencer.sv
module tb_trigger_sequencer;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int RW  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 trig;
  logic [NCH-1:0]       en;
  logic [NCH*CW-1:0]    dly, len, per;
  logic [NCH*RW-1:0]    rep;
  logic [NCH-1:0]       o_trig, o_busy, o_miss;

  trigger_sequencer #(
    .NUM_CHANNELS (NCH),
    .COUNT_WIDTH  (CW),
    .REPEAT_WIDTH (RW)
  ) dut (
    .ipClk     (clk),
    .ipReset   (rst),
    .ipTrigger (trig),
    .ipEnable  (en),
    .ipDelay   (dly),
    .ipLength  (len),
    .ipPeriod  (per),
    .ipRepeat  (rep),
    .opTrigger (o_trig),
    .opBusy    (o_busy),
    .opMissed  (o_miss)
  );

  typedef struct {
    int             cyc;
    logic [NCH-1:0] t;
    logic [NCH-1:0] b;
    logic [NCH-1:0] m;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cur_cyc = 0;

  // Reference model: each accepted sequence is described by its start cycle
  // and latched parameters; outputs are derived arithmetically from those.
  bit     act [NCH];
  longint t0  [NCH];
  longint md  [NCH];
  longint ml  [NCH];
  longint mpe [NCH];
  longint mr  [NCH];
  bit     prev_trig = 1'b0;
  bit     prev_rst  = 1'b1;

  function automatic bit m_busy(int c, longint n);
    if (!act[c]) return 1'b0;
    return (n >= t0[c] + 1) && (n <= t0[c] + md[c] + (mr[c] - 1) * mpe[c] + ml[c]);
  endfunction

  function automatic bit m_trig(int c, longint n);
    longint k;
    if (!act[c]) return 1'b0;
    k = n - (t0[c] + 1 + md[c]);
    if (k < 0) return 1'b0;
    return ((k / mpe[c]) < mr[c]) && ((k % mpe[c]) < ml[c]);
  endfunction

  // Model the current cycle's inputs, queue the expected outputs of the next
  // cycle, then advance one clock.
  task automatic tick();
    exp_t e;
    bit   edge_n;
    bit   bz;
    int   n;
    logic [CW-1:0] d_c, l_c, p_c;
    logic [RW-1:0] r_c;
    n     = cur_cyc;
    e.cyc = n + 1;
    e.t   = '0;
    e.b   = '0;
    e.m   = '0;
    if (rst) begin
      for (int c = 0; c < NCH; c++) act[c] = 1'b0;
    end else begin
      edge_n = trig && !prev_trig && !prev_rst;
      for (int c = 0; c < NCH; c++) begin
        d_c = dly[c*CW +: CW];
        l_c = len[c*CW +: CW];
        p_c = per[c*CW +: CW];
        r_c = rep[c*RW +: RW];
        bz  = m_busy(c, n);
        e.m[c] = edge_n && bz;
        if (bz && !en[c]) begin
          act[c] = 1'b0;
        end else if (!bz && edge_n && en[c] && (l_c != 0)) begin
          act[c] = 1'b1;
          t0[c]  = n;
          md[c]  = longint'(d_c);
          ml[c]  = longint'(l_c);
          mpe[c] = (p_c > l_c) ? longint'(p_c) : longint'(l_c) + 1;
          mr[c]  = (r_c == 0) ? 1 : longint'(r_c);
        end
        e.t[c] = m_trig(c, n + 1);
        e.b[c] = m_busy(c, n + 1);
      end
    end
    prev_trig = trig;
    prev_rst  = rst;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cur_cyc = n + 1;
  endtask

  task automatic idle(int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  task automatic set_ch(int c, int d, int l, int p, int r);
    dly[c*CW +: CW] = CW'(d);
    len[c*CW +: CW] = CW'(l);
    per[c*CW +: CW] = CW'(p);
    rep[c*RW +: RW] = RW'(r);
  endtask

  // Monitor: compares the DUT against the queued expectation for this cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      if (sb[0].cyc == cur_cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if (o_trig !== e.t || o_busy !== e.b || o_miss !== e.m) begin
          n_err++;
          $display("FAIL outputs cyc %0d: trig got %b want %b, busy got %b want %b, missed got %b want %b",
                   e.cyc, o_trig, e.t, o_busy, e.b, o_miss, e.m);
        end
      end else if (sb[0].cyc < cur_cyc) begin
        e = sb.pop_front();
        n_cmp++;
        n_err++;
        $display("FAIL stale_expectation cyc %0d: checked at %0d want %0d", e.cyc, cur_cyc, e.cyc);
      end
    end
  end

  initial begin
    rst  = 1'b1;
    trig = 1'b0;
    en   = '0;
    dly  = '0;
    len  = '0;
    per  = '0;
    rep  = '0;
    @(posedge clk);
    #1;
    cur_cyc = 0;

    // reset
    idle(3);
    rst = 1'b0;
    en  = 4'b0001;
    idle(4);

    // single pulse
    set_ch(0, 3, 2, 0, 1);
    idle(2);
    pulse_trig();
    idle(10);

    // burst
    set_ch(0, 0, 2, 5, 3);
    pulse_trig();
    idle(18);

    // short period (Peff = L+1)
    set_ch(0, 0, 3, 2, 2);
    pulse_trig();
    idle(12);

    // missed edge then re-arm on first non-busy cycle
    set_ch(0, 3, 2, 0, 1);
    pulse_trig();
    idle(2);
    pulse_trig();
    idle(2);
    pulse_trig();
    idle(10);

    // independence and abort
    en = 4'b0011;
    set_ch(0, 0, 100, 0, 1);
    set_ch(1, 5, 1, 0, 1);
    pulse_trig();
    idle(19);
    en[0] = 1'b0;
    idle(4);
    en[0] = 1'b1;

    // reset in the middle of a burst
    set_ch(0, 0, 2, 5, 3);
    set_ch(1, 1, 3, 4, 2);
    pulse_trig();
    idle(6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(4);

    // trigger held high across reset release is not an edge
    trig = 1'b1;
    rst  = 1'b1;
    idle(2);
    rst  = 1'b0;
    idle(4);
    trig = 1'b0;
    idle(3);

    // counter boundaries: full-scale delay/length, Peff = L+1 at full scale,
    // repeat 0 treated as 1, length 0 ignored
    en = 4'b1111;
    set_ch(0, 2, 0, 3, 2);
    set_ch(1, 1, 1, 0, 0);
    set_ch(2, 255, 255, 0, 2);
    set_ch(3, 0, 255, 255, 2);
    pulse_trig();
    // change live config mid-sequence; must not affect running channels
    set_ch(2, 1, 1, 1, 1);
    set_ch(3, 1, 1, 1, 1);
    idle(800);

    // randomized traffic
    for (int i = 0; i < 6000; i++) begin
      rst = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 5) == 0) trig = ~trig;
      for (int c = 0; c < NCH; c++) begin
        if (en[c]) begin
          if ($urandom_range(0, 299) == 0) en[c] = 1'b0;
        end else if ($urandom_range(0, 9) == 0) begin
          en[c] = 1'b1;
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        set_ch(int'($urandom_range(0, NCH - 1)),
               ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 10)),
               int'($urandom_range(0, 6)),
               int'($urandom_range(0, 12)),
               int'($urandom_range(0, 4)));
      end
      tick();
    end

    rst  = 1'b0;
    trig = 1'b0;
    idle(2);
    @(negedge clk);
    #1;
    if (sb.size() > 1) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: left %0d want at most 1", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_trigger_sequencer
